// File: rtl/pool_buf_sched.sv
// Ping-pong bank scheduler for the pooled feature-map RAM: producer fills one bank while the consumer drains the other.
// Optional POOL_BUF_SCHED_PERF_EN adds saturating request-stall counters for both sides.
module pool_buf_sched #(
    parameter int DATA_WIDTH      = 16,
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int FRAME_WORDS     = 588
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       prod_req,
    output logic                       prod_gnt,
    input  logic                       prod_done,
    input  logic                       prod_wren,
    input  logic                       prod_rden,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_addr,
    input  logic [DATA_WIDTH-1:0]      prod_data,
    output logic [DATA_WIDTH-1:0]      prod_q,
    input  logic                       cons_req,
    output logic                       cons_gnt,
    input  logic                       cons_done,
    input  logic                       cons_rden,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_addr,
    output logic [DATA_WIDTH-1:0]      cons_q,
    output logic [POOL_ADDR_WIDTH:0]   ram_addr_a,
    output logic [POOL_ADDR_WIDTH:0]   ram_addr_b,
    output logic                       ram_wren_a,
    output logic                       ram_rden_a,
    output logic                       ram_wren_b,
    output logic                       ram_rden_b,
    output logic [DATA_WIDTH-1:0]      ram_data_a,
    input  logic [DATA_WIDTH-1:0]      ram_q_a,
    input  logic [DATA_WIDTH-1:0]      ram_q_b,
    output logic [1:0]                 full_cnt,
`ifdef POOL_BUF_SCHED_PERF_EN
    output logic                       err_oor,
    output logic [31:0]                prod_stall_cnt,
    output logic [31:0]                cons_stall_cnt
`else
    output logic                       err_oor
`endif
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
    typedef enum logic {P_IDLE, P_FILL} p_state_t;
    typedef enum logic {C_IDLE, C_DRAIN} c_state_t;

    localparam logic [POOL_ADDR_WIDTH:0] FRAME_LIM = FRAME_WORDS[POOL_ADDR_WIDTH:0];

    p_state_t p_st, p_nxt;
    c_state_t c_st, c_nxt;
    bank_t    bank_st  [2];
    bank_t    bank_nxt [2];
    logic     wr_bank, rd_bank;
    logic     prod_take, prod_fin, cons_take, cons_fin;
    logic     prod_in, cons_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_st       <= P_IDLE;
            c_st       <= C_IDLE;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
        end else begin
            p_st       <= p_nxt;
            c_st       <= c_nxt;
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
            if (prod_fin) wr_bank <= ~wr_bank;
            if (cons_fin) rd_bank <= ~rd_bank;
        end
    end

    // Grants look only at registered bank status, so a bank released this edge is grantable next edge.
    always_comb begin
        p_nxt     = p_st;
        prod_take = 1'b0;
        prod_fin  = 1'b0;
        case (p_st)
            P_IDLE: if (prod_req && bank_st[wr_bank] == B_EMPTY) begin
                p_nxt     = P_FILL;
                prod_take = 1'b1;
            end
            P_FILL: if (prod_done) begin
                p_nxt    = P_IDLE;
                prod_fin = 1'b1;
            end
            default: p_nxt = P_IDLE;
        endcase
    end

    always_comb begin
        c_nxt     = c_st;
        cons_take = 1'b0;
        cons_fin  = 1'b0;
        case (c_st)
            C_IDLE: if (cons_req && bank_st[rd_bank] == B_FULL) begin
                c_nxt     = C_DRAIN;
                cons_take = 1'b1;
            end
            C_DRAIN: if (cons_done) begin
                c_nxt    = C_IDLE;
                cons_fin = 1'b1;
            end
            default: c_nxt = C_IDLE;
        endcase
    end

    // Producer and consumer never touch the same bank in one edge: EMPTY/FILLING vs FULL/DRAINING.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (prod_take && wr_bank == 1'(b)) bank_nxt[b] = B_FILLING;
            if (prod_fin  && wr_bank == 1'(b)) bank_nxt[b] = B_FULL;
            if (cons_take && rd_bank == 1'(b)) bank_nxt[b] = B_DRAINING;
            if (cons_fin  && rd_bank == 1'(b)) bank_nxt[b] = B_EMPTY;
        end
    end

    assign prod_gnt = (p_st == P_FILL);
    assign cons_gnt = (c_st == C_DRAIN);
    assign full_cnt = {1'b0, bank_st[0] == B_FULL} + {1'b0, bank_st[1] == B_FULL};

    assign prod_in    = {1'b0, prod_addr} < FRAME_LIM;
    assign cons_in    = {1'b0, cons_addr} < FRAME_LIM;
    assign ram_addr_a = {wr_bank, prod_addr};
    assign ram_addr_b = {rd_bank, cons_addr};
    assign ram_data_a = prod_data;
    assign ram_wren_a = prod_wren & prod_gnt & prod_in;
    assign ram_rden_a = prod_rden & prod_gnt & prod_in;
    assign ram_rden_b = cons_rden & cons_gnt & cons_in;
    assign ram_wren_b = 1'b0;
    assign prod_q     = ram_q_a;
    assign cons_q     = ram_q_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_oor <= 1'b0;
        else if ((prod_gnt && (prod_wren || prod_rden) && !prod_in) ||
                 (cons_gnt && cons_rden && !cons_in))
            err_oor <= 1'b1;
    end

`ifdef POOL_BUF_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_stall_cnt <= '0;
            cons_stall_cnt <= '0;
        end else begin
            if (prod_req && !prod_gnt && prod_stall_cnt != '1) prod_stall_cnt <= prod_stall_cnt + 32'd1;
            if (cons_req && !cons_gnt && cons_stall_cnt != '1) cons_stall_cnt <= cons_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_buf_sched.sv
// Directed bench for pool_buf_sched; expected values are queued when stimulus is applied and popped at each check.
module tb_pool_buf_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        prod_req, prod_done, prod_wren, prod_rden;
    logic [9:0]  prod_addr;
    logic [15:0] prod_data, prod_q;
    logic        cons_req, cons_done, cons_rden;
    logic [9:0]  cons_addr;
    logic [15:0] cons_q;
    logic        prod_gnt, cons_gnt;
    logic [10:0] ram_addr_a, ram_addr_b;
    logic        ram_wren_a, ram_rden_a, ram_wren_b, ram_rden_b;
    logic [15:0] ram_data_a, ram_q_a, ram_q_b;
    logic [1:0]  full_cnt;
    logic        err_oor;
`ifdef POOL_BUF_SCHED_PERF_EN
    logic [31:0] prod_stall_cnt, cons_stall_cnt;
    logic [31:0] stall_base;
`endif

    int          checks = 0;
    int          errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pool_buf_sched dut (
        .clk(clk), .reset(reset),
        .prod_req(prod_req), .prod_gnt(prod_gnt), .prod_done(prod_done),
        .prod_wren(prod_wren), .prod_rden(prod_rden), .prod_addr(prod_addr),
        .prod_data(prod_data), .prod_q(prod_q),
        .cons_req(cons_req), .cons_gnt(cons_gnt), .cons_done(cons_done),
        .cons_rden(cons_rden), .cons_addr(cons_addr), .cons_q(cons_q),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_wren_a(ram_wren_a), .ram_rden_a(ram_rden_a),
        .ram_wren_b(ram_wren_b), .ram_rden_b(ram_rden_b),
        .ram_data_a(ram_data_a), .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .full_cnt(full_cnt),
`ifdef POOL_BUF_SCHED_PERF_EN
        .err_oor(err_oor),
        .prod_stall_cnt(prod_stall_cnt), .cons_stall_cnt(cons_stall_cnt)
`else
        .err_oor(err_oor)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        prod_req = 0; prod_done = 0; prod_wren = 0; prod_rden = 0;
        prod_addr = '0; prod_data = '0;
        cons_req = 0; cons_done = 0; cons_rden = 0; cons_addr = '0;
        ram_q_a = '0; ram_q_b = '0;
        tick(); tick();
        push("rst_prod_gnt", 0); chk(32'(prod_gnt));
        push("rst_cons_gnt", 0); chk(32'(cons_gnt));
        push("rst_full_cnt", 0); chk(32'(full_cnt));
        push("rst_err_oor", 0);  chk(32'(err_oor));

        // enables while nothing is granted
        reset = 1'b1;
        prod_wren = 1; prod_rden = 1; prod_addr = 10'd1; cons_rden = 1; cons_addr = 10'd1;
        push("ungranted_en", 0);
        #1 chk(32'({ram_wren_a, ram_rden_a, ram_rden_b, ram_wren_b}));
        prod_wren = 0; prod_rden = 0; cons_rden = 0;

        // done without grant is ignored
        prod_done = 1; cons_done = 1;
        tick();
        prod_done = 0; cons_done = 0;
        push("stray_done_full", 0); chk(32'(full_cnt));
        push("stray_done_gnt", 0);  chk(32'({prod_gnt, cons_gnt}));

        // consumer waits while no bank is full
        cons_req = 1;
        tick(); tick();
        push("cons_no_full", 0); chk(32'(cons_gnt));

        prod_req = 1;
        tick();
        push("prod_gnt_1edge", 1); chk(32'(prod_gnt));
        prod_addr = 10'd5; prod_wren = 1; prod_data = 16'h1234; ram_q_a = 16'hbeef;
        push("wren_a", 1);       push("addr_a_b0", 5);
        push("data_a", 16'h1234); push("prod_q", 16'hbeef);
        #1;
        chk(32'(ram_wren_a)); chk(32'(ram_addr_a)); chk(32'(ram_data_a)); chk(32'(prod_q));

        prod_wren = 0; prod_req = 0; prod_done = 1;
        tick();
        prod_done = 0;
        push("fill_done_gnt", 0);  chk(32'(prod_gnt));
        push("fill_done_full", 1); chk(32'(full_cnt));
        push("cons_not_yet", 0);   chk(32'(cons_gnt));
        tick();
        push("cons_gnt_next", 1);  chk(32'(cons_gnt));
        push("drain_full_cnt", 0); chk(32'(full_cnt));

        cons_rden = 1; cons_addr = 10'd7; ram_q_b = 16'h55aa;
        push("rden_b", 1); push("addr_b_b0", 7); push("cons_q", 16'h55aa);
        #1;
        chk(32'(ram_rden_b)); chk(32'(ram_addr_b)); chk(32'(cons_q));
        cons_rden = 0; cons_req = 0; cons_done = 1;
        tick();
        cons_done = 0;
        push("drain_done_gnt", 0); chk(32'(cons_gnt));

        // fill bank1 then bank0, then producer must stall
        prod_req = 1;
        tick();
        push("gnt_bank1", 1); chk(32'(prod_gnt));
        prod_addr = 10'd3;
        push("addr_a_b1", 11'd1027);
        #1 chk(32'(ram_addr_a));
        prod_done = 1;
        tick();
        prod_done = 0;
        push("gap_after_done", 0); chk(32'(prod_gnt));
        tick();
        push("gnt_bank0", 1);      chk(32'(prod_gnt));
        push("addr_a_b0_again", 11'd3);
        chk(32'(ram_addr_a));
        prod_done = 1;
        tick();
        prod_done = 0;
        push("both_full_cnt", 2); chk(32'(full_cnt));
        tick(); tick();
        push("both_full_stall", 0); chk(32'(prod_gnt));
`ifdef POOL_BUF_SCHED_PERF_EN
        stall_base = prod_stall_cnt;
        push("prod_stall_cnt", stall_base + 32'd10);
        repeat (10) tick();
        chk(prod_stall_cnt);
`endif

        // drain bank1; producer regains it two edges after cons_done
        cons_req = 1;
        tick();
        push("cons_gnt_b1", 1);  chk(32'(cons_gnt));
        push("full_cnt_drain", 1); chk(32'(full_cnt));
        cons_rden = 1; cons_addr = 10'd0;
        push("addr_b_b1", 11'd1024);
        #1 chk(32'(ram_addr_b));
        cons_rden = 0; cons_done = 1; cons_req = 0;
        tick();
        cons_done = 0;
        push("release_edge_gnt", 0); chk(32'(prod_gnt));
        push("release_full_cnt", 1); chk(32'(full_cnt));
        tick();
        push("release_gnt_2edge", 1); chk(32'(prod_gnt));
        push("addr_a_b1_again", 11'd1027); chk(32'(ram_addr_a));

        // address range boundary
        prod_addr = 10'd587; prod_wren = 1;
        push("wren_last_word", 1);
        #1 chk(32'(ram_wren_a));
        prod_addr = 10'd588;
        push("wren_oor_blocked", 0); push("err_before_edge", 0);
        #1;
        chk(32'(ram_wren_a)); chk(32'(err_oor));
        tick();
        push("err_oor_set", 1); chk(32'(err_oor));
        prod_wren = 0; prod_addr = 10'd1;
        tick(); tick();
        push("err_oor_sticky", 1); chk(32'(err_oor));

        // reset in the middle of a fill
        prod_wren = 1;
        #2 reset = 1'b0;
        push("midrst_gnt", 0); push("midrst_full", 0);
        push("midrst_err", 0); push("midrst_wren", 0);
        #1;
        chk(32'(prod_gnt)); chk(32'(full_cnt)); chk(32'(err_oor)); chk(32'(ram_wren_a));
        prod_wren = 0;
        tick();
        reset = 1'b1;
        tick();
        push("post_rst_gnt", 1);     chk(32'(prod_gnt));
        push("post_rst_bank0", 11'd1); chk(32'(ram_addr_a));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
